m_cache_refill_ctrl: RTL and testbench

Read-miss sequencer for the 4-word write-noallocate data cache. It accepts word loads from the pipeline and presents them to the cache. On a miss it stalls the requester and fetches the 16-byte line from main memory as four 32-bit beats. It then installs the line through the cache install port and returns the requested word. It sits between the load path, `m_cache` and the memory port; stores bypass this block.

---
 rtl/m_cache_refill_ctrl.sv | 161 ++++++++++++++++
 tb/tb_m_cache_refill_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_cache_refill_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : m_cache_refill_ctrl
// Brief    : Read-miss sequencer for the 4-word data cache. Serves load hits
//            from the cache, stalls on a miss, fetches the 16-byte line as four
//            32-bit memory beats, installs it and returns the requested word.
// Options  : CACHE_CRITICAL_WORD_FIRST_EN - fetch the requested word first and
//            answer the load as soon as that beat arrives.
// Revision : 1.0 - initial release
// ============================================================================
module m_cache_refill_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  o_stall,
    output logic                  o_rvalid,
    output logic [31:0]           o_rdata,
    output logic [ADDR_WIDTH-1:0] o_cache_raddr,
    input  logic                  i_cache_hit,
    input  logic [127:0]          i_cache_rdata,
    input  logic [1:0]            i_cache_bindex,
    output logic                  o_cache_bwe,
    output logic [ADDR_WIDTH-1:0] o_cache_waddr,
    output logic [127:0]          o_cache_bdata,
    output logic                  o_mem_req,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic                  i_mem_ack,
    input  logic [31:0]           i_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        FILL    = 2'd2,
        INSTALL = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_beat;
    logic [3:0][31:0]      r_buf;
    logic [31:0]           r_rdata;
    logic [31:0]           w_rdata;
    logic [1:0]            w_beat_start;
    logic                  w_early_valid;
    logic                  w_install_rvalid;
    logic                  w_accept;
    logic                  w_ack;
    logic                  w_last_beat;

    // Stall is purely a function of state and the lookup result
    assign o_stall  = (r_state == FILL) | ((r_state == LOOKUP) & ~i_cache_hit);
    assign w_accept = i_req & ~o_stall;
    // Acks outside FILL are not associated with any outstanding beat
    assign w_ack    = (r_state == FILL) & i_mem_ack;
    // Beats wrap modulo 4, so the last one is the beat just before the start
    assign w_last_beat = ((r_beat + 2'd1) == w_beat_start);

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    logic r_early;

    assign w_beat_start     = r_addr[3:2];
    assign w_early_valid    = r_early;
    assign w_install_rvalid = 1'b0;

    // Flag the cycle after the requested word lands in the buffer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_early <= 1'b0;
        end else begin
            r_early <= w_ack & (r_beat == w_beat_start);
        end
    end
`else
    assign w_beat_start     = 2'd0;
    assign w_early_valid    = 1'b0;
    assign w_install_rvalid = 1'b1;
`endif

    // State, captured address, beat counter, line buffer and held read data
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_beat  <= 2'd0;
            r_buf   <= '0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr <= i_addr;
            end
            if ((r_state == LOOKUP) && !i_cache_hit) begin
                r_beat <= w_beat_start;
            end else if (w_ack) begin
                r_buf[r_beat] <= i_mem_rdata;
                r_beat        <= r_beat + 2'd1;
            end
            if (o_rvalid) begin
                r_rdata <= w_rdata;
            end
        end
    end

    // Next-state decode and per-state strobes
    always_comb begin
        w_next        = r_state;
        o_rvalid      = 1'b0;
        o_cache_bwe   = 1'b0;
        o_mem_req     = 1'b0;
        o_cache_raddr = r_addr;
        w_rdata       = r_buf[r_addr[3:2]];
        case (r_state)
            IDLE: begin
                o_cache_raddr = i_addr;
                if (i_req) begin
                    w_next = LOOKUP;
                end
            end
            LOOKUP: begin
                if (i_cache_hit) begin
                    o_rvalid      = 1'b1;
                    w_rdata       = i_cache_rdata[{i_cache_bindex, 5'd0} +: 32];
                    o_cache_raddr = i_addr;
                    w_next        = i_req ? LOOKUP : IDLE;
                end else begin
                    w_next = FILL;
                end
            end
            FILL: begin
                o_mem_req = 1'b1;
                o_rvalid  = w_early_valid;
                if (i_mem_ack && w_last_beat) begin
                    w_next = INSTALL;
                end
            end
            INSTALL: begin
                o_cache_bwe   = 1'b1;
                o_rvalid      = w_install_rvalid;
                o_cache_raddr = i_addr;
                w_next        = i_req ? LOOKUP : IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Read data is held between responses
    assign o_rdata       = o_rvalid ? w_rdata : r_rdata;
    assign o_mem_addr    = {r_addr[ADDR_WIDTH-1:4], r_beat, 2'b00};
    assign o_cache_waddr = {r_addr[ADDR_WIDTH-1:4], 4'b0000};
    assign o_cache_bdata = r_buf;

endmodule
`default_nettype wire

// File: tb/tb_m_cache_refill_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_m_cache_refill_ctrl
// Brief    : Directed self-checking bench for m_cache_refill_ctrl with a small
//            behavioural cache and a memory responder returning data=address.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m_cache_refill_ctrl;

    localparam int AW = 32;

    logic           i_clk = 1'b0;
    logic           i_rst_n;
    logic           i_req;
    logic [AW-1:0]  i_addr;
    logic           o_stall;
    logic           o_rvalid;
    logic [31:0]    o_rdata;
    logic [AW-1:0]  o_cache_raddr;
    logic           i_cache_hit;
    logic [127:0]   i_cache_rdata;
    logic [1:0]     i_cache_bindex;
    logic           o_cache_bwe;
    logic [AW-1:0]  o_cache_waddr;
    logic [127:0]   o_cache_bdata;
    logic           o_mem_req;
    logic [AW-1:0]  o_mem_addr;
    logic           i_mem_ack = 1'b0;
    logic [31:0]    i_mem_rdata = 32'd0;

    int n_total = 0;
    int n_bad   = 0;
    int rv_cnt  = 0;
    int bwe_cnt = 0;
    int wait_n  = 0;
    int wcnt    = 0;

    m_cache_refill_ctrl #(.ADDR_WIDTH(AW)) u_dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .o_stall        (o_stall),
        .o_rvalid       (o_rvalid),
        .o_rdata        (o_rdata),
        .o_cache_raddr  (o_cache_raddr),
        .i_cache_hit    (i_cache_hit),
        .i_cache_rdata  (i_cache_rdata),
        .i_cache_bindex (i_cache_bindex),
        .o_cache_bwe    (o_cache_bwe),
        .o_cache_waddr  (o_cache_waddr),
        .o_cache_bdata  (o_cache_bdata),
        .o_mem_req      (o_mem_req),
        .o_mem_addr     (o_mem_addr),
        .i_mem_ack      (i_mem_ack),
        .i_mem_rdata    (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural direct-mapped cache, 1-cycle read latency
    logic [255:0]  cm_vld;
    logic [AW-1:0] cm_tag  [256];
    logic [127:0]  cm_line [256];
    logic [AW-1:0] cm_rq;
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [127:0]  pre_data;

    always @(posedge i_clk) begin
        cm_rq <= o_cache_raddr;
        if (!i_rst_n) begin
            cm_vld <= '0;
        end else if (pre_we) begin
            cm_vld[pre_addr[11:4]]  <= 1'b1;
            cm_tag[pre_addr[11:4]]  <= {pre_addr[AW-1:4], 4'b0000};
            cm_line[pre_addr[11:4]] <= pre_data;
        end else if (o_cache_bwe) begin
            cm_vld[o_cache_waddr[11:4]]  <= 1'b1;
            cm_tag[o_cache_waddr[11:4]]  <= o_cache_waddr;
            cm_line[o_cache_waddr[11:4]] <= o_cache_bdata;
        end
    end

    assign i_cache_hit    = cm_vld[cm_rq[11:4]] && (cm_tag[cm_rq[11:4]] == {cm_rq[AW-1:4], 4'b0000});
    assign i_cache_rdata  = cm_line[cm_rq[11:4]];
    assign i_cache_bindex = cm_rq[3:2];

    // Memory responder: wait_n idle cycles before each acked beat
    always @(negedge i_clk) begin
        if (!o_mem_req) begin
            i_mem_ack = 1'b0;
            wcnt      = 0;
        end else begin
            if (i_mem_ack) wcnt = 0;
            if (wcnt == wait_n) begin
                i_mem_ack = 1'b1;
            end else begin
                i_mem_ack = 1'b0;
                wcnt      = wcnt + 1;
            end
        end
        i_mem_rdata = o_mem_addr;
    end

    // Count responses and installs for exactly-once checks
    always @(negedge i_clk) begin
        if (o_rvalid)    rv_cnt  = rv_cnt + 1;
        if (o_cache_bwe) bwe_cnt = bwe_cnt + 1;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic samp();
        @(negedge i_clk);
        #1;
    endtask

    // One load that misses; optional same-line load in the INSTALL cycle
    task automatic run_miss(input logic [31:0] a, input int w, input bit rdi);
        logic [31:0]  line;
        logic [31:0]  word;
        logic [127:0] exp_line;
        int start, inst, rv_rel, k, rv0, bw0;
        line     = {a[31:4], 4'b0000};
        word     = {a[31:2], 2'b00};
        exp_line = {line + 32'd12, line + 32'd8, line + 32'd4, line};
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
        start  = int'(a[3:2]);
        rv_rel = 3 + w;
`else
        start  = 0;
        rv_rel = 6 + 4 * w;
`endif
        inst = 6 + 4 * w;
        rv0  = rv_cnt;
        bw0  = bwe_cnt;
        i_req  = 1'b1;
        i_addr = a;
        samp();
        check("miss_acc_stall", o_stall, 0);
        tick();
        i_req = 1'b0;
        for (int rel = 1; rel <= inst; rel++) begin
            samp();
            check("miss_rvalid", o_rvalid, (rel == rv_rel));
            if (rel == rv_rel) check("miss_rdata", o_rdata, word);
            if (rel == 1) begin
                check("lookup_stall", o_stall, 1);
                check("lookup_mem_req", o_mem_req, 0);
            end else if (rel < inst) begin
                k = (rel - 2) / (w + 1);
                check("fill_mem_req", o_mem_req, 1);
                check("fill_stall", o_stall, 1);
                check("fill_mem_addr", o_mem_addr, line + 32'(4 * ((start + k) % 4)));
            end else begin
                check("inst_bwe", o_cache_bwe, 1);
                check("inst_waddr", o_cache_waddr, line);
                check("inst_bdata", o_cache_bdata, exp_line);
                check("inst_stall", o_stall, 0);
                check("inst_mem_req", o_mem_req, 0);
                if (rdi) begin
                    i_req  = 1'b1;
                    i_addr = line + 32'd4;
                end
            end
            tick();
            i_req = 1'b0;
        end
        if (rdi) begin
            samp();
            check("rdi_rvalid", o_rvalid, 1);
            check("rdi_rdata", o_rdata, line + 32'd4);
            check("rdi_stall", o_stall, 0);
            check("rdi_mem_req", o_mem_req, 0);
            tick();
        end
        samp();
        check("post_rvalid", o_rvalid, 0);
        check("post_mem_req", o_mem_req, 0);
        check("post_bwe", o_cache_bwe, 0);
        check("post_rdata_hold", o_rdata, rdi ? line + 32'd4 : word);
        tick();
        check("miss_rv_count", rv_cnt - rv0, rdi ? 2 : 1);
        check("miss_bwe_count", bwe_cnt - bw0, 1);
    endtask

    initial begin
        int rv0, bw0;
        i_rst_n  = 1'b0;
        i_req    = 1'b1;
        i_addr   = 32'h100;
        pre_we   = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        wait_n   = 0;

        // Reset held with a pending request
        repeat (3) @(posedge i_clk);
        samp();
        check("rst_stall", o_stall, 0);
        check("rst_rvalid", o_rvalid, 0);
        check("rst_bwe", o_cache_bwe, 0);
        check("rst_mem_req", o_mem_req, 0);
        check("rst_rdata", o_rdata, 0);
        check("rst_mem_addr", o_mem_addr, 0);
        check("rst_waddr", o_cache_waddr, 0);
        check("rst_bdata", o_cache_bdata, 0);
        check("rst_rv_count", rv_cnt, 0);
        tick();
        i_req   = 1'b0;
        i_rst_n = 1'b1;

        // Pre-install line 0x100
        pre_we   = 1'b1;
        pre_addr = 32'h100;
        pre_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        tick();
        pre_we = 1'b0;

        // Back-to-back hits
        i_req  = 1'b1;
        i_addr = 32'h104;
        samp();
        check("hit0_stall", o_stall, 0);
        tick();
        i_addr = 32'h10C;
        samp();
        check("hit1_rvalid", o_rvalid, 1);
        check("hit1_rdata", o_rdata, 32'hA1);
        check("hit1_stall", o_stall, 0);
        tick();
        i_req = 1'b0;
        samp();
        check("hit2_rvalid", o_rvalid, 1);
        check("hit2_rdata", o_rdata, 32'hA3);
        check("hit2_stall", o_stall, 0);
        tick();
        samp();
        check("hit_idle_rvalid", o_rvalid, 0);
        check("hit_hold_rdata", o_rdata, 32'hA3);
        tick();

        // Miss without waits, plus a same-line load during INSTALL
        run_miss(32'h208, 0, 1'b1);

        // Miss with three wait states per beat
        wait_n = 3;
        run_miss(32'h308, 3, 1'b0);
        wait_n = 0;

        // Reset in the middle of a fill
        i_req  = 1'b1;
        i_addr = 32'h408;
        tick();
        i_req = 1'b0;
        samp();
        tick();
        samp();
        check("mf_mem_req_pre", o_mem_req, 1);
        rv0 = rv_cnt;
        bw0 = bwe_cnt;
        i_rst_n = 1'b0;
        #1;
        check("mf_mem_req", o_mem_req, 0);
        check("mf_stall", o_stall, 0);
        check("mf_rvalid", o_rvalid, 0);
        check("mf_bdata", o_cache_bdata, 0);
        check("mf_mem_addr", o_mem_addr, 0);
        tick();
        tick();
        i_rst_n = 1'b1;
        repeat (8) tick();
        check("mf_no_rvalid", rv_cnt - rv0, 0);
        check("mf_no_install", bwe_cnt - bw0, 0);
        check("mf_idle_mem_req", o_mem_req, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
